ta_feedback_engine: RTL and testbench

TA_FEEDBACK_ENGINE -- requirements
Module: ta_feedback_engine

---
 rtl/tm_pkg.sv | 21 ++
 rtl/ta_next_state.sv | 39 +++
 rtl/ta_feedback_engine.sv | 88 ++++++++
 tb/tb_ta_feedback_engine.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/tm_pkg.sv
// Shared encodings for the Tsetlin automaton feedback engine: feedback types,
// sequencer states and the reset/centre state helper.
package tm_pkg;

  localparam logic [1:0] FB_NONE    = 2'b00;
  localparam logic [1:0] FB_REWARD  = 2'b01;
  localparam logic [1:0] FB_PENALTY = 2'b10;
  localparam logic [1:0] FB_RSVD    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_DONE   = 2'd2
  } fsm_state_t;

  // Highest exclude state: one step below the include/exclude boundary.
  function automatic int centre_state(input int state_bits);
    return (1 << (state_bits - 1)) - 1;
  endfunction

endpackage

// File: rtl/ta_next_state.sv
// Combinational saturating step for one Tsetlin automaton: reward pushes the
// state away from the centre, penalty pulls it one step toward the centre.
module ta_next_state
  import tm_pkg::*;
#(
  parameter int STATE_BITS = 3
) (
  input  logic [STATE_BITS-1:0] state,
  input  logic [1:0]            fb_type,
  input  logic                  enable,
  output logic [STATE_BITS-1:0] next_state
);

  localparam logic [STATE_BITS-1:0] ST_MAX = '1;
  localparam logic [STATE_BITS-1:0] ST_MIN = '0;

  logic incl;
  assign incl = state[STATE_BITS-1];

  always_comb begin
    next_state = state;
    if (enable) begin
      case (fb_type)
        FB_REWARD: begin
          if (incl) begin
            if (state != ST_MAX) next_state = state + 1'b1;
          end else begin
            if (state != ST_MIN) next_state = state - 1'b1;
          end
        end
        // Penalty never saturates: include states sit at or above the
        // boundary and exclude states below it, so one step stays in range.
        FB_PENALTY: next_state = incl ? state - 1'b1 : state + 1'b1;
        default:    next_state = state;
      endcase
    end
  end

endmodule

// File: rtl/ta_feedback_engine.sv
// Bank of Tsetlin automata updated by a sequencer that walks one TA per cycle
// through a single shared step unit; fixed latency regardless of mask/type.
module ta_feedback_engine
  import tm_pkg::*;
#(
  parameter int NUM_TA     = 4,
  parameter int STATE_BITS = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           fb_valid,
  output logic                           fb_ready,
  input  logic [1:0]                     fb_type,
  input  logic [NUM_TA-1:0]              fb_mask,
  output logic                           busy,
  output logic                           done,
  output logic [NUM_TA-1:0]              ta_include,
  output logic [NUM_TA*STATE_BITS-1:0]   state_flat
);

  localparam int IDX_W = (NUM_TA > 1) ? $clog2(NUM_TA) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_TA - 1);
  localparam logic [STATE_BITS-1:0] RST_STATE = STATE_BITS'(centre_state(STATE_BITS));

  fsm_state_t                             fsm;
  logic [IDX_W-1:0]                       idx;
  logic [1:0]                             req_type;
  logic [NUM_TA-1:0]                      req_mask;
  logic [NUM_TA-1:0][STATE_BITS-1:0]      ta_state;
  logic [STATE_BITS-1:0]                  nxt_state;

  ta_next_state #(.STATE_BITS(STATE_BITS)) u_step (
    .state      (ta_state[idx]),
    .fb_type    (req_type),
    .enable     (req_mask[idx]),
    .next_state (nxt_state)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm      <= ST_IDLE;
      idx      <= '0;
      fb_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      req_type <= FB_NONE;
      req_mask <= '0;
      for (int i = 0; i < NUM_TA; i++) ta_state[i] <= RST_STATE;
    end else begin
      case (fsm)
        ST_IDLE: begin
          if (fb_valid) begin
            req_type <= fb_type;
            req_mask <= fb_mask;
            idx      <= '0;
            fsm      <= ST_UPDATE;
            fb_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        // Every index takes its cycle even when masked off, keeping latency fixed.
        ST_UPDATE: begin
          ta_state[idx] <= nxt_state;
          if (idx == LAST_IDX) begin
            fsm  <= ST_DONE;
            done <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          fsm      <= ST_IDLE;
          done     <= 1'b0;
          busy     <= 1'b0;
          fb_ready <= 1'b1;
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end

  assign state_flat = ta_state;

  for (genvar i = 0; i < NUM_TA; i++) begin : g_incl
    assign ta_include[i] = ta_state[i][STATE_BITS-1];
  end

endmodule

// File: tb/tb_ta_feedback_engine.sv
// Self-checking bench for ta_feedback_engine: vector table, corner sequences
// and random requests checked against an arithmetic model of the TA bank.
module tb_ta_feedback_engine;

  localparam int NUM_TA = 4;
  localparam int SB     = 3;
  localparam int HALF   = 1 << (SB - 1);
  localparam int MAXV   = (1 << SB) - 1;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  fb_valid = 1'b0;
  logic                  fb_ready;
  logic [1:0]            fb_type = 2'b00;
  logic [NUM_TA-1:0]     fb_mask = '0;
  logic                  busy;
  logic                  done;
  logic [NUM_TA-1:0]     ta_include;
  logic [NUM_TA*SB-1:0]  state_flat;

  int n_chk  = 0;
  int n_fail = 0;
  int model [NUM_TA];

  typedef struct {
    logic [1:0]           t;
    logic [NUM_TA-1:0]    m;
    logic [NUM_TA*SB-1:0] exp_flat;
    logic [NUM_TA-1:0]    exp_inc;
  } vec_t;

  vec_t vecs [13];

  ta_feedback_engine #(.NUM_TA(NUM_TA), .STATE_BITS(SB)) dut (
    .clk        (clk),
    .reset      (reset),
    .fb_valid   (fb_valid),
    .fb_ready   (fb_ready),
    .fb_type    (fb_type),
    .fb_mask    (fb_mask),
    .busy       (busy),
    .done       (done),
    .ta_include (ta_include),
    .state_flat (state_flat)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int step(input int s, input logic [1:0] t, input bit en);
    if (!en || t == 2'b00 || t == 2'b11) return s;
    if (t == 2'b01) begin
      if (s >= HALF) return (s + 1 > MAXV) ? MAXV : s + 1;
      return (s - 1 < 0) ? 0 : s - 1;
    end
    return (s >= HALF) ? s - 1 : s + 1;
  endfunction

  function automatic logic [NUM_TA*SB-1:0] pack(input int a [NUM_TA]);
    logic [NUM_TA*SB-1:0] r;
    r = '0;
    for (int j = 0; j < NUM_TA; j++) r[j*SB +: SB] = SB'(a[j]);
    return r;
  endfunction

  function automatic logic [NUM_TA-1:0] inc_of(input int a [NUM_TA]);
    logic [NUM_TA-1:0] r;
    for (int j = 0; j < NUM_TA; j++) r[j] = (a[j] >= HALF);
    return r;
  endfunction

  // One full request: accept, watch each TA change on its own edge, then done.
  task automatic run_req(input logic [1:0] t, input logic [NUM_TA-1:0] m, input bit hold);
    int old_s [NUM_TA];
    int new_s [NUM_TA];
    int part  [NUM_TA];
    int w;
    for (int j = 0; j < NUM_TA; j++) begin
      old_s[j] = model[j];
      new_s[j] = step(model[j], t, m[j]);
    end
    w = 0;
    while (fb_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    check("ready_wait", 64'(fb_ready), 64'(1));
    fb_valid = 1'b1; fb_type = t; fb_mask = m;
    @(posedge clk); #1;
    check("accept_busy", 64'({busy, fb_ready}), 64'(2'b10));
    if (hold) begin
      fb_type = 2'b01; fb_mask = '1;
    end else begin
      fb_valid = 1'b0; fb_type = 2'($urandom); fb_mask = NUM_TA'($urandom);
    end
    for (int k = 1; k <= NUM_TA; k++) begin
      @(posedge clk); #1;
      for (int j = 0; j < NUM_TA; j++) part[j] = (j < k) ? new_s[j] : old_s[j];
      check("per_edge_state", 64'(state_flat), 64'(pack(part)));
      check("per_edge_incl", 64'(ta_include), 64'(inc_of(part)));
      check("done_timing", 64'(done), 64'(k == NUM_TA));
    end
    fb_valid = 1'b0;
    for (int j = 0; j < NUM_TA; j++) model[j] = new_s[j];
    @(posedge clk); #1;
    check("after_done", 64'({done, fb_ready, busy}), 64'(3'b010));
  endtask

  initial begin
    vecs[0]  = '{2'b10, 4'b0001, 12'h6DC, 4'b0001};
    vecs[1]  = '{2'b01, 4'b0011, 12'h6D5, 4'b0001};
    vecs[2]  = '{2'b01, 4'b0011, 12'h6CE, 4'b0001};
    vecs[3]  = '{2'b01, 4'b0011, 12'h6C7, 4'b0001};
    vecs[4]  = '{2'b01, 4'b0011, 12'h6C7, 4'b0001};
    vecs[5]  = '{2'b11, 4'b1111, 12'h6C7, 4'b0001};
    vecs[6]  = '{2'b00, 4'b1111, 12'h6C7, 4'b0001};
    vecs[7]  = '{2'b10, 4'b1111, 12'h90E, 4'b1101};
    vecs[8]  = '{2'b10, 4'b0100, 12'h8CE, 4'b1001};
    vecs[9]  = '{2'b01, 4'b0000, 12'h8CE, 4'b1001};
    vecs[10] = '{2'b10, 4'b0001, 12'h8CD, 4'b1001};
    vecs[11] = '{2'b10, 4'b0001, 12'h8CC, 4'b1001};
    vecs[12] = '{2'b10, 4'b0001, 12'h8CB, 4'b1000};

    for (int j = 0; j < NUM_TA; j++) model[j] = HALF - 1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 64'(state_flat), 64'(12'h6DB));
    check("rst_flags", 64'({fb_ready, busy, done}), 64'(3'b100));
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_state", 64'(state_flat), 64'(12'h6DB));
    check("post_rst_incl", 64'(ta_include), 64'(0));

    // Vector table
    for (int v = 0; v < 13; v++) begin
      run_req(vecs[v].t, vecs[v].m, 1'b0);
      check("vec_state", 64'(state_flat), 64'(vecs[v].exp_flat));
      check("vec_incl", 64'(ta_include), 64'(vecs[v].exp_inc));
    end

    // Valid held high while busy with a different request: nothing queued
    run_req(2'b00, 4'b0000, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
      check("no_second_req", 64'({busy, done, fb_ready}), 64'(3'b001));
      check("hold_state", 64'(state_flat), 64'(pack(model)));
    end
    run_req(2'b10, 4'b0010, 1'b1);
    check("hold_latched", 64'(state_flat), 64'(pack(model)));

    // Reset in the middle of a penalty on every TA
    @(posedge clk); #1;
    fb_valid = 1'b1; fb_type = 2'b10; fb_mask = 4'b1111;
    @(posedge clk); #1;
    fb_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("abort_state", 64'(state_flat), 64'(12'h6DB));
    check("abort_flags", 64'({fb_ready, busy, done}), 64'(3'b100));
    @(posedge clk); #1;
    reset = 1'b0;
    for (int j = 0; j < NUM_TA; j++) model[j] = HALF - 1;
    begin
      int seen_done;
      seen_done = 0;
      repeat (6) begin
        @(posedge clk); #1;
        if (done === 1'b1 || busy === 1'b1) seen_done++;
      end
      check("abort_no_resume", 64'(seen_done), 64'(0));
    end
    run_req(2'b11, 4'b1111, 1'b0);
    check("rsvd_state", 64'(state_flat), 64'(12'h6DB));

    // Random requests against the model
    for (int r = 0; r < 40; r++)
      run_req(2'($urandom_range(0, 3)), NUM_TA'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
